// File: rtl/ray_pkg.sv
// Shared definitions for the ray word assembler.
// Word layout, slot count and FSM state encoding.
package ray_pkg;

  localparam int WORD_W        = 36;
  localparam int PAY_W         = 32;
  localparam int SOP_BIT       = 35;
  localparam int IDX_HI        = 34;
  localparam int IDX_LO        = 32;
  localparam int PAY_HI        = 31;
  localparam int PAY_LO        = 0;
  localparam int WORDS_PER_RAY = 6;

  localparam logic [2:0] REQ_MAX   = 3'(WORDS_PER_RAY);
  localparam logic [2:0] LAST_SLOT = 3'(WORDS_PER_RAY - 1);

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_COLLECT,
    ST_HOLD
  } ray_state_t;

  function automatic logic word_sop(input logic [WORD_W-1:0] w);
    return w[SOP_BIT];
  endfunction

  function automatic logic [2:0] word_idx(input logic [WORD_W-1:0] w);
    return w[IDX_HI:IDX_LO];
  endfunction

  function automatic logic [PAY_W-1:0] word_pay(input logic [WORD_W-1:0] w);
    return w[PAY_HI:PAY_LO];
  endfunction

endpackage

// File: rtl/ray_word_capture.sv
// Read-valid tracker for the 1-cycle FIFO latency
// plus the six 32-bit payload slots of one ray.
module ray_word_capture
  import ray_pkg::*;
(
  input  logic             rd_clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [2:0]       wr_slot,
  input  logic [PAY_W-1:0] payload,
  output logic             rd_valid,
  output logic [95:0]      origin,
  output logic [95:0]      dir
);

  logic [PAY_W-1:0] slot_q [WORDS_PER_RAY];

  // Data on the FIFO bus is valid the cycle after a read strobe.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
    end
  end

  // Store a captured payload into its slot.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WORDS_PER_RAY; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < WORDS_PER_RAY; k++) begin
        if (wr_en && (wr_slot == 3'(k))) begin
          slot_q[k] <= payload;
        end
      end
    end
  end

  assign origin = {slot_q[2], slot_q[1], slot_q[0]};
  assign dir    = {slot_q[5], slot_q[4], slot_q[3]};

endmodule

// File: rtl/ray_word_assembler.sv
// Assembles six FIFO words into one ray (origin, dir).
// RAY_TAG_CHECK_EN enables SOP/index checks and err_cnt.
module ray_word_assembler
  import ray_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic              rd_clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [35:0]       fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              ray_valid,
  input  logic              ray_ready,
  output logic [95:0]       ray_origin,
  output logic [95:0]       ray_dir,
  output logic [ERR_W-1:0]  err_cnt
);

  ray_state_t state;
  logic [2:0] req_cnt;
  logic [2:0] rcv_cnt;
  logic [2:0] rd_inc;
  logic       rd_valid;
  logic       start_ok;
  logic       tag_err;
  logic       wr_en;
  logic [2:0] wr_slot;

  // Reads stop in HOLD, once six are issued, or when empty.
  assign fifo_rd_en = rst_n && !fifo_empty
                    && (state != ST_HOLD)
                    && (req_cnt < REQ_MAX);

  assign rd_inc = {2'b00, fifo_rd_en};

`ifdef RAY_TAG_CHECK_EN
  logic       cap_sop;
  logic [2:0] cap_idx;

  assign cap_sop  = word_sop(fifo_rd_data);
  assign cap_idx  = word_idx(fifo_rd_data);
  assign start_ok = cap_sop && (cap_idx == 3'd0);
  assign tag_err  = (state == ST_COLLECT)
                  && (cap_sop || (cap_idx != rcv_cnt));
`else
  logic unused_tag;

  assign unused_tag = ^fifo_rd_data[35:32];
  assign start_ok   = 1'b1;
  assign tag_err    = 1'b0;
`endif

  // Decide whether the captured word lands in a slot, and which.
  always_comb begin
    wr_en   = 1'b0;
    wr_slot = rcv_cnt;
    if (rd_valid) begin
      unique case (1'b1)
        state == ST_SYNC: begin
          wr_en   = start_ok;
          wr_slot = 3'd0;
        end
        state == ST_COLLECT && !tag_err: begin
          wr_en = 1'b1;
        end
        state == ST_COLLECT && tag_err: begin
          wr_en   = start_ok;
          wr_slot = 3'd0;
        end
        default: begin
          wr_en = 1'b0;
        end
      endcase
    end
  end

  ray_word_capture u_capture (
    .rd_clk   (rd_clk),
    .rst_n    (rst_n),
    .rd_en    (fifo_rd_en),
    .wr_en    (wr_en),
    .wr_slot  (wr_slot),
    .payload  (word_pay(fifo_rd_data)),
    .rd_valid (rd_valid),
    .origin   (ray_origin),
    .dir      (ray_dir)
  );

  // Packet FSM; req_cnt always equals rcv_cnt plus the read in flight.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SYNC;
      req_cnt   <= '0;
      rcv_cnt   <= '0;
      ray_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_SYNC: begin
          if (rd_valid && start_ok) begin
            state   <= ST_COLLECT;
            rcv_cnt <= 3'd1;
            req_cnt <= req_cnt + rd_inc;
          end else if (rd_valid) begin
            req_cnt <= req_cnt + rd_inc - 3'd1;
          end else begin
            req_cnt <= req_cnt + rd_inc;
          end
        end
        ST_COLLECT: begin
          if (rd_valid && tag_err) begin
            if (start_ok) begin
              rcv_cnt <= 3'd1;
              req_cnt <= 3'd1 + rd_inc;
            end else begin
              state   <= ST_SYNC;
              rcv_cnt <= 3'd0;
              req_cnt <= rd_inc;
            end
          end else if (rd_valid) begin
            rcv_cnt <= rcv_cnt + 3'd1;
            req_cnt <= req_cnt + rd_inc;
            if (rcv_cnt == LAST_SLOT) begin
              state     <= ST_HOLD;
              ray_valid <= 1'b1;
            end
          end else begin
            req_cnt <= req_cnt + rd_inc;
          end
        end
        ST_HOLD: begin
          if (ray_ready) begin
            state     <= ST_SYNC;
            req_cnt   <= '0;
            rcv_cnt   <= '0;
            ray_valid <= 1'b0;
          end
        end
        default: begin
          state <= ST_SYNC;
        end
      endcase
    end
  end

`ifdef RAY_TAG_CHECK_EN
  // Count dropped packets, sticking at all-ones.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (rd_valid && tag_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ray_word_assembler.sv
// Directed bench for ray_word_assembler with a FIFO model.
// Tag-check cases build only with RAY_TAG_CHECK_EN.
module tb_ray_word_assembler;

  logic        rd_clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic [35:0] fifo_rd_data;
  logic        fifo_rd_en;
  logic        ray_valid;
  logic        ray_ready;
  logic [95:0] ray_origin;
  logic [95:0] ray_dir;
  logic [7:0]  err_cnt;

  logic [35:0] mem [0:2047];
  logic [10:0] wp = '0;
  logic [10:0] rp = '0;
  logic        gate_empty = 1'b0;
  logic        fifo_flush = 1'b0;

  int total = 0;
  int bad   = 0;
  int viol_empty = 0;
  int viol_hold  = 0;

  ray_word_assembler #(.ERR_W(8)) dut (
    .rd_clk       (rd_clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .ray_valid    (ray_valid),
    .ray_ready    (ray_ready),
    .ray_origin   (ray_origin),
    .ray_dir      (ray_dir),
    .err_cnt      (err_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  assign fifo_empty = gate_empty | (wp == rp);

  always @(posedge rd_clk) begin
    if (fifo_flush) begin
      rp <= wp;
    end else if (fifo_rd_en && (wp != rp)) begin
      fifo_rd_data <= mem[rp];
      rp <= rp + 11'd1;
    end
  end

  always begin
    @(negedge rd_clk);
    #2;
    if (fifo_rd_en && fifo_empty) viol_empty++;
    if (fifo_rd_en && ray_valid) viol_hold++;
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] mkw(input logic sop,
                                      input logic [2:0] idx,
                                      input logic [31:0] pay);
    return {sop, idx, pay};
  endfunction

  task automatic push(input logic [35:0] w);
    mem[wp] = w;
    wp = wp + 11'd1;
  endtask

  task automatic push_pkt(input logic [31:0] base);
    for (int k = 0; k < 6; k++) begin
      push(mkw(k == 0, 3'(k), base + 32'(k)));
    end
  endtask

  function automatic logic [95:0] eorg(input logic [31:0] b);
    return {b + 32'd2, b + 32'd1, b};
  endfunction

  function automatic logic [95:0] edir(input logic [31:0] b);
    return {b + 32'd5, b + 32'd4, b + 32'd3};
  endfunction

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (!ray_valid && n < lim) begin
      @(negedge rd_clk);
      n++;
    end
  endtask

  task automatic take(input string tag);
    ray_ready = 1'b1;
    @(negedge rd_clk);
    chk(tag, ray_valid, 1'b0);
    ray_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic st_ok;

    rst_n     = 1'b0;
    ray_ready = 1'b0;
    repeat (2) @(negedge rd_clk);
    push_pkt(32'h1000_0000);
    @(negedge rd_clk);
    chk("rst_valid", ray_valid, 1'b0);
    chk("rst_rden", fifo_rd_en, 1'b0);
    chk("rst_org", ray_origin, 96'd0);
    chk("rst_dir", ray_dir, 96'd0);
    chk("rst_err", err_cnt, 8'd0);

    rst_n = 1'b1;
    wait_valid(20, n);
    chk("a_lat", n, 7);
    chk("a_org", ray_origin, 96'h10000002_10000001_10000000);
    chk("a_dir", ray_dir, 96'h10000005_10000004_10000003);
    take("a_drop");

    push_pkt(32'h2000_0000);
    push_pkt(32'h3000_0000);
    wait_valid(20, n);
    chk("b_valid", ray_valid, 1'b1);
    chk("b_org", ray_origin, eorg(32'h2000_0000));
    chk("b_dir", ray_dir, edir(32'h2000_0000));
    st_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge rd_clk);
      if (ray_valid !== 1'b1 || fifo_rd_en !== 1'b0
          || ray_origin !== eorg(32'h2000_0000)
          || ray_dir !== edir(32'h2000_0000)) st_ok = 1'b0;
    end
    chk("b_hold_stable", st_ok, 1'b1);
    take("b_drop");
    wait_valid(20, n);
    chk("c_thru", n, 7);
    chk("c_org", ray_origin, eorg(32'h3000_0000));
    chk("c_dir", ray_dir, edir(32'h3000_0000));
    take("c_drop");

    push_pkt(32'h4000_0000);
    gate_empty = 1'b1;
    n = 0;
    while (!ray_valid && n < 60) begin
      @(negedge rd_clk);
      gate_empty = ~gate_empty;
      n++;
    end
    gate_empty = 1'b0;
    chk("d_valid", ray_valid, 1'b1);
    chk("d_org", ray_origin, eorg(32'h4000_0000));
    chk("d_dir", ray_dir, edir(32'h4000_0000));
    take("d_drop");

`ifndef RAY_TAG_CHECK_EN
    for (int k = 0; k < 6; k++) begin
      push(mkw(1'b0, 3'd7, 32'h5000_0000 + 32'(k)));
    end
    wait_valid(20, n);
    chk("notag_lat", n, 7);
    chk("notag_org", ray_origin, eorg(32'h5000_0000));
    chk("notag_dir", ray_dir, edir(32'h5000_0000));
    chk("notag_err", err_cnt, 8'd0);
    take("notag_drop");
`endif

    push_pkt(32'h6000_0000);
    repeat (4) @(negedge rd_clk);
    chk("r_pre_valid", ray_valid, 1'b0);
    fifo_flush = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("r_valid", ray_valid, 1'b0);
    chk("r_rden", fifo_rd_en, 1'b0);
    chk("r_org", ray_origin, 96'd0);
    @(negedge rd_clk);
    fifo_flush = 1'b0;
    @(negedge rd_clk);
    rst_n = 1'b1;
    push_pkt(32'h7000_0000);
    wait_valid(20, n);
    chk("r_lat", n, 7);
    chk("r_org2", ray_origin, eorg(32'h7000_0000));
    chk("r_dir2", ray_dir, edir(32'h7000_0000));
    take("r_drop");

`ifdef RAY_TAG_CHECK_EN
    push(mkw(1'b1, 3'd0, 32'hA000_0000));
    push(mkw(1'b0, 3'd1, 32'hA000_0001));
    push(mkw(1'b0, 3'd2, 32'hA000_0002));
    push(mkw(1'b0, 3'd4, 32'hA000_0004));
    push_pkt(32'h8000_0000);
    wait_valid(30, n);
    chk("t_valid", ray_valid, 1'b1);
    chk("t_org", ray_origin, eorg(32'h8000_0000));
    chk("t_dir", ray_dir, edir(32'h8000_0000));
    chk("t_err", err_cnt, 8'd1);
    take("t_drop");

    for (int p = 0; p < 300; p++) begin
      push(mkw(1'b1, 3'd0, 32'hB000_0000));
      push(mkw(1'b0, 3'd2, 32'hB000_0002));
    end
    n = 0;
    while (wp != rp && n < 2000) begin
      @(negedge rd_clk);
      n++;
    end
    repeat (3) @(negedge rd_clk);
    chk("sat_drained", wp == rp, 1'b1);
    chk("sat_err", err_cnt, 8'd255);
    chk("sat_valid", ray_valid, 1'b0);
`endif

    chk("rden_vs_empty", viol_empty, 0);
    chk("rden_in_hold", viol_hold, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
